// File: rtl/srff.sv
// srff: bank of WIDTH independent clocked set/reset storage bits.
// Each bit latches a set or reset request on the rising edge of clk. The
// response to a simultaneous set and reset is fixed at build time by
// SR11_MODE. A registered per-bit flag marks the cycle after s=r=1 was seen.
module srff #(
  parameter int                 WIDTH     = 1,
  parameter int                 SR11_MODE = 0,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] illegal
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] illegal_q;
  logic [WIDTH-1:0] illegal_d;

  // Per-bit next state; the s=r=1 case is resolved by SR11_MODE, and
  // unsupported mode values fall back to hold.
  always_comb begin
    q_d       = q_q;
    illegal_d = s & r;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({s[i], r[i]})
        2'b10:   q_d[i] = 1'b1;
        2'b01:   q_d[i] = 1'b0;
        2'b11: begin
          case (SR11_MODE)
            1:       q_d[i] = 1'b1;
            2:       q_d[i] = 1'b0;
            3:       q_d[i] = ~q_q[i];
            default: q_d[i] = q_q[i];
          endcase
        end
        default: q_d[i] = q_q[i];
      endcase
    end
  end

  // State and illegal-flag registers; reset takes priority over s and r.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= RESET_VAL;
      illegal_q <= '0;
    end else begin
      q_q       <= q_d;
      illegal_q <= illegal_d;
    end
  end

  // Outputs come straight from the registers; qn is an inverter on q only.
  always_comb begin
    q       = q_q;
    qn      = ~q_q;
    illegal = illegal_q;
  end

endmodule

// File: tb/tb_srff.sv
// Testbench for srff: directed vector table on WIDTH=1 instances of every
// SR11_MODE, hand sequences on WIDTH=4, and a randomised run with a model.
module tb_srff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=1 instances, one per SR11_MODE, sharing stimulus
  logic       rst1, s1, r1;
  logic [3:0] q1, qn1, il1;

  // WIDTH=4 instances, one per SR11_MODE, RESET_VAL=1010, sharing stimulus
  logic       rst4;
  logic [3:0] s4, r4;
  logic [3:0] q4  [4];
  logic [3:0] qn4 [4];
  logic [3:0] il4 [4];

  // out-of-range mode, must behave as hold
  logic [3:0] q5, qn5, il5;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    srff #(.WIDTH(1), .SR11_MODE(m), .RESET_VAL(1'b0)) u_w1 (
      .clk(clk), .rst(rst1), .s(s1), .r(r1),
      .q(q1[m]), .qn(qn1[m]), .illegal(il1[m])
    );
    srff #(.WIDTH(4), .SR11_MODE(m), .RESET_VAL(4'b1010)) u_w4 (
      .clk(clk), .rst(rst4), .s(s4), .r(r4),
      .q(q4[m]), .qn(qn4[m]), .illegal(il4[m])
    );
  end

  srff #(.WIDTH(4), .SR11_MODE(5), .RESET_VAL(4'b1010)) u_w4_m5 (
    .clk(clk), .rst(rst4), .s(s4), .r(r4),
    .q(q5), .qn(qn5), .illegal(il5)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, act, exp);
    end
  endtask

  // Reference next state for one WIDTH=4 bank
  function automatic logic [3:0] model(input int mode, input logic [3:0] q,
                                       input logic [3:0] s, input logic [3:0] r);
    logic [3:0] n;
    for (int i = 0; i < 4; i++) begin
      if (s[i] && r[i]) begin
        if (mode == 1)      n[i] = 1'b1;
        else if (mode == 2) n[i] = 1'b0;
        else if (mode == 3) n[i] = ~q[i];
        else                n[i] = q[i];
      end else if (s[i]) n[i] = 1'b1;
      else if (r[i])     n[i] = 1'b0;
      else               n[i] = q[i];
    end
    return n;
  endfunction

  // eq holds the expected q for modes {3,2,1,0}
  typedef struct {
    logic       rst;
    logic       s;
    logic       r;
    logic [3:0] eq;
    logic       ill;
  } vec_t;

  vec_t tbl[$];

  task automatic edge4(input logic rst_v, input logic [3:0] s_v, input logic [3:0] r_v);
    @(negedge clk);
    rst4 = rst_v; s4 = s_v; r4 = r_v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] mq [5];
    logic [3:0] mil;

    rst1 = 1'b1; s1 = 1'b0; r1 = 1'b0;
    rst4 = 1'b1; s4 = '0;   r4 = '0;

    tbl.push_back('{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b1111, 1'b0});
    for (int k = 0; k < 10; k++) tbl.push_back('{1'b0, 1'b0, 1'b0, 4'b1111, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 4'b0011, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 4'b0011, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b1111, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 4'b0011, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 4'b1011, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 4'b0011, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 4'b0011, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b1111, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4'b0000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b1111, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 4'b0000, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0});

    foreach (tbl[k]) begin
      @(negedge clk);
      rst1 = tbl[k].rst; s1 = tbl[k].s; r1 = tbl[k].r;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_q", k), q1, tbl[k].eq);
      chk($sformatf("vec%0d_qn", k), qn1, ~tbl[k].eq);
      chk($sformatf("vec%0d_illegal", k), il1, {4{tbl[k].ill}});
    end

    // WIDTH=4: reset value, then independent set/reset of separate bits
    edge4(1'b1, 4'b1111, 4'b0000);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("w4_rst_q_m%0d", m), q4[m], 4'b1010);
      chk($sformatf("w4_rst_qn_m%0d", m), qn4[m], 4'b0101);
      chk($sformatf("w4_rst_ill_m%0d", m), il4[m], 4'b0000);
    end
    chk("w4_rst_q_m5", q5, 4'b1010);
    edge4(1'b0, 4'b0001, 4'b1000);
    for (int m = 0; m < 4; m++)
      chk($sformatf("w4_bits_q_m%0d", m), q4[m], 4'b0011);
    // mixed per-bit s=r=1 on bits 3 and 1 from q=0011
    edge4(1'b0, 4'b1010, 4'b1010);
    chk("w4_sr11_m0", q4[0], 4'b0011);
    chk("w4_sr11_m1", q4[1], 4'b1011);
    chk("w4_sr11_m2", q4[2], 4'b0001);
    chk("w4_sr11_m3", q4[3], 4'b1001);
    chk("w4_sr11_m5", q5, 4'b0011);
    chk("w4_sr11_ill", il4[0], 4'b1010);
    edge4(1'b0, 4'b0000, 4'b0000);
    chk("w4_ill_clear", il4[3], 4'b0000);

    // Randomised run against the model, with random reset pulses
    edge4(1'b1, 4'b0000, 4'b0000);
    for (int m = 0; m < 5; m++) mq[m] = 4'b1010;
    mil = 4'b0000;
    for (int k = 0; k < 200; k++) begin
      logic       rv;
      logic [3:0] sv, rv4;
      rv  = ($urandom_range(0, 15) == 0);
      sv  = 4'($urandom_range(0, 15));
      rv4 = 4'($urandom_range(0, 15));
      edge4(rv, sv, rv4);
      for (int m = 0; m < 5; m++)
        mq[m] = rv ? 4'b1010 : model(m, mq[m], sv, rv4);
      mil = rv ? 4'b0000 : (sv & rv4);
      for (int m = 0; m < 4; m++) begin
        chk($sformatf("rnd%0d_q_m%0d", k, m), q4[m], mq[m]);
        chk($sformatf("rnd%0d_qn_m%0d", k, m), qn4[m], ~q4[m]);
        chk($sformatf("rnd%0d_ill_m%0d", k, m), il4[m], mil);
      end
      chk($sformatf("rnd%0d_q_m5", k), q5, mq[4]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
